// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and widths for the write-back port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PREG_W = 6;
    localparam int unsigned ROB_W  = 5;

    // One buffered execution-unit result.
    typedef struct packed {
        logic [XLEN-1:0]   data;
        logic [PREG_W-1:0] dest;
        logic [ROB_W-1:0]  rob;
        logic              wb;
    } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_rr_pick2.sv
// Combinational two-winner round-robin selector.
module wb_port_arbiter_rr_pick2 #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  vld,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             g0_v,
    output logic [IDX_W-1:0] g0_idx,
    output logic             g1_v,
    output logic [IDX_W-1:0] g1_idx,
    output logic [IDX_W-1:0] next_ptr
);

    function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
        return IDX_W'(v % NREQ);
    endfunction

    // Scan from rr_ptr with wrap; first valid to port 0, second to port 1.
    always_comb begin
        g0_v     = 1'b0;
        g0_idx   = '0;
        g1_v     = 1'b0;
        g1_idx   = '0;
        next_ptr = rr_ptr;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (vld[wrap_idx(32'(rr_ptr) + i)]) begin
                if (!g0_v) begin
                    g0_v   = 1'b1;
                    g0_idx = wrap_idx(32'(rr_ptr) + i);
                end else if (!g1_v) begin
                    g1_v   = 1'b1;
                    g1_idx = wrap_idx(32'(rr_ptr) + i);
                end
            end
        end
        if (g1_v) begin
            next_ptr = wrap_idx(32'(g1_idx) + 1);
        end else if (g0_v) begin
            next_ptr = wrap_idx(32'(g0_idx) + 1);
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the two register-file write ports among NREQ result sources.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic                   cpu_clock_i,
    input  logic                   cpu_reset_i,
    input  logic                   flush_i,
    input  logic [NREQ-1:0]        req_vld_i,
    input  logic [NREQ-1:0]        req_wb_i,
    input  logic [NREQ*XLEN-1:0]   req_data_i,
    input  logic [NREQ*PREG_W-1:0] req_dest_i,
    input  logic [NREQ*ROB_W-1:0]  req_rob_i,
    output logic [NREQ-1:0]        req_rdy_o,
    output logic                   p0_wen,
    output logic [XLEN-1:0]        p0_we_data,
    output logic [PREG_W-1:0]      p0_we_dest,
    output logic                   p1_wen,
    output logic [XLEN-1:0]        p1_we_data,
    output logic [PREG_W-1:0]      p1_we_dest,
    output logic                   alu0_complete,
    output logic [ROB_W-1:0]       alu0_rob_id,
    output logic                   alu1_complete,
    output logic [ROB_W-1:0]       alu1_rob_id,
    output logic                   alu0_reg_ready,
    output logic [PREG_W-1:0]      alu0_reg_dest,
    output logic                   alu1_reg_ready,
    output logic [PREG_W-1:0]      alu1_reg_dest
);

    wb_req_t          in_req [NREQ];
    wb_req_t          buf_q  [NREQ];
    logic [NREQ-1:0]  buf_v;
    logic [IDX_W-1:0] rr_ptr;
    logic [NREQ-1:0]  grant;
    logic             g0_v;
    logic             g1_v;
    logic [IDX_W-1:0] g0_idx;
    logic [IDX_W-1:0] g1_idx;
    logic [IDX_W-1:0] next_ptr;
    wb_req_t          sel0;
    wb_req_t          sel1;

    // Unpack the flat source buses into per-source payloads.
    for (genvar n = 0; n < NREQ; n++) begin : g_unpack
        assign in_req[n] = '{data: req_data_i[XLEN*n +: XLEN],
                             dest: req_dest_i[PREG_W*n +: PREG_W],
                             rob:  req_rob_i[ROB_W*n +: ROB_W],
                             wb:   req_wb_i[n]};
    end

    wb_port_arbiter_rr_pick2 #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .vld      (buf_v),
        .rr_ptr   (rr_ptr),
        .g0_v     (g0_v),
        .g0_idx   (g0_idx),
        .g1_v     (g1_v),
        .g1_idx   (g1_idx),
        .next_ptr (next_ptr)
    );

    // One-hot-per-port grant vector.
    always_comb begin
        grant = '0;
        if (g0_v) grant[g0_idx] = 1'b1;
        if (g1_v) grant[g1_idx] = 1'b1;
    end

    assign sel0 = buf_q[g0_idx];
    assign sel1 = buf_q[g1_idx];

    // A slot draining this cycle can refill; during flush every handshake completes and is dropped.
    assign req_rdy_o = ~buf_v | grant | {NREQ{flush_i}};

    // Holding-buffer payloads; validity is tracked separately.
    always_ff @(posedge cpu_clock_i) begin
        for (int unsigned n = 0; n < NREQ; n++) begin
            if (req_vld_i[n] && req_rdy_o[n]) buf_q[n] <= in_req[n];
        end
    end

    // Buffer valid bits, round-robin pointer and registered port outputs.
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            buf_v         <= '0;
            rr_ptr        <= '0;
            p0_wen        <= 1'b0;
            p1_wen        <= 1'b0;
            alu0_complete <= 1'b0;
            alu1_complete <= 1'b0;
            p0_we_data    <= '0;
            p1_we_data    <= '0;
            p0_we_dest    <= '0;
            p1_we_dest    <= '0;
            alu0_rob_id   <= '0;
            alu1_rob_id   <= '0;
        end else if (flush_i) begin
            buf_v         <= '0;
            p0_wen        <= 1'b0;
            p1_wen        <= 1'b0;
            alu0_complete <= 1'b0;
            alu1_complete <= 1'b0;
        end else begin
            for (int unsigned n = 0; n < NREQ; n++) begin
                if (req_vld_i[n] && req_rdy_o[n]) begin
                    buf_v[n] <= 1'b1;
                end else if (grant[n]) begin
                    buf_v[n] <= 1'b0;
                end
            end
            rr_ptr        <= next_ptr;
            alu0_complete <= g0_v;
            alu1_complete <= g1_v;
            p0_wen        <= g0_v & sel0.wb;
            p1_wen        <= g1_v & sel1.wb;
            if (g0_v) begin
                p0_we_data  <= sel0.data;
                p0_we_dest  <= sel0.dest;
                alu0_rob_id <= sel0.rob;
            end
            if (g1_v) begin
                p1_we_data  <= sel1.data;
                p1_we_dest  <= sel1.dest;
                alu1_rob_id <= sel1.rob;
            end
        end
    end

    // Wakeup mirrors the write port.
    assign alu0_reg_ready = p0_wen;
    assign alu1_reg_ready = p1_wen;
    assign alu0_reg_dest  = p0_we_dest;
    assign alu1_reg_dest  = p1_we_dest;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for the write-back port arbiter.
module tb_wb_port_arbiter;

    localparam int unsigned NREQ = 4;

    logic                 clk = 1'b0;
    logic                 cpu_reset;
    logic                 flush;
    logic [NREQ-1:0]      req_vld;
    logic [NREQ-1:0]      req_wb;
    logic [NREQ*32-1:0]   req_data;
    logic [NREQ*6-1:0]    req_dest;
    logic [NREQ*5-1:0]    req_rob;
    logic [NREQ-1:0]      req_rdy;
    logic                 p0_wen, p1_wen;
    logic [31:0]          p0_we_data, p1_we_data;
    logic [5:0]           p0_we_dest, p1_we_dest;
    logic                 alu0_complete, alu1_complete;
    logic [4:0]           alu0_rob_id, alu1_rob_id;
    logic                 alu0_reg_ready, alu1_reg_ready;
    logic [5:0]           alu0_reg_dest, alu1_reg_dest;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.NREQ(NREQ)) dut (
        .cpu_clock_i    (clk),
        .cpu_reset_i    (cpu_reset),
        .flush_i        (flush),
        .req_vld_i      (req_vld),
        .req_wb_i       (req_wb),
        .req_data_i     (req_data),
        .req_dest_i     (req_dest),
        .req_rob_i      (req_rob),
        .req_rdy_o      (req_rdy),
        .p0_wen         (p0_wen),
        .p0_we_data     (p0_we_data),
        .p0_we_dest     (p0_we_dest),
        .p1_wen         (p1_wen),
        .p1_we_data     (p1_we_data),
        .p1_we_dest     (p1_we_dest),
        .alu0_complete  (alu0_complete),
        .alu0_rob_id    (alu0_rob_id),
        .alu1_complete  (alu1_complete),
        .alu1_rob_id    (alu1_rob_id),
        .alu0_reg_ready (alu0_reg_ready),
        .alu0_reg_dest  (alu0_reg_dest),
        .alu1_reg_ready (alu1_reg_ready),
        .alu1_reg_dest  (alu1_reg_dest)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_vld  = '0;
        req_wb   = '0;
        req_data = '0;
        req_dest = '0;
        req_rob  = '0;
    endtask

    task automatic set_src(input int n, input logic [31:0] d, input logic [5:0] dst,
                           input logic [4:0] rb, input logic w);
        req_vld[n]           = 1'b1;
        req_wb[n]            = w;
        req_data[32*n +: 32] = d;
        req_dest[6*n +: 6]   = dst;
        req_rob[5*n +: 5]    = rb;
    endtask

    task automatic do_reset();
        cpu_reset = 1'b1;
        flush     = 1'b0;
        clear_inputs();
        tick();
        tick();
        cpu_reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({p0_wen, p1_wen, alu0_complete, alu1_complete, alu0_reg_ready, alu1_reg_ready} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 000000",
                     {p0_wen, p1_wen, alu0_complete, alu1_complete, alu0_reg_ready, alu1_reg_ready});
        end
        checks++;
        if ({p0_we_data, p1_we_data, p0_we_dest, p1_we_dest, alu0_rob_id, alu1_rob_id} !== '0) begin
            failures++;
            $display("FAIL reset_payload: got %h %h %h %h %h %h expected all 0",
                     p0_we_data, p1_we_data, p0_we_dest, p1_we_dest, alu0_rob_id, alu1_rob_id);
        end
        checks++;
        if (req_rdy !== 4'hF) begin
            failures++;
            $display("FAIL reset_rdy: got %b expected 1111", req_rdy);
        end
        checks++;
        if (dut.rr_ptr !== 2'd0) begin
            failures++;
            $display("FAIL reset_ptr: got %0d expected 0", dut.rr_ptr);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_src(1, 32'hDEADBEEF, 6'd12, 5'd7, 1'b1);
        tick();
        clear_inputs();
        checks++;
        if (req_rdy !== 4'hF) begin
            failures++;
            $display("FAIL single_rdy: got %b expected 1111", req_rdy);
        end
        tick();
        checks++;
        if ({p0_wen, alu0_complete, alu0_reg_ready, p0_we_data, p0_we_dest, alu0_rob_id, alu0_reg_dest}
            !== {1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 6'd12, 5'd7, 6'd12}) begin
            failures++;
            $display("FAIL single_p0: got wen=%b cmp=%b rr=%b data=%h dest=%0d rob=%0d rdest=%0d expected 1 1 1 deadbeef 12 7 12",
                     p0_wen, alu0_complete, alu0_reg_ready, p0_we_data, p0_we_dest, alu0_rob_id, alu0_reg_dest);
        end
        checks++;
        if ({p1_wen, alu1_complete, alu1_reg_ready} !== 3'b000) begin
            failures++;
            $display("FAIL single_p1_idle: got %b expected 000", {p1_wen, alu1_complete, alu1_reg_ready});
        end
        checks++;
        if (req_rdy !== 4'hF) begin
            failures++;
            $display("FAIL single_rdy2: got %b expected 1111", req_rdy);
        end
        tick();
        checks++;
        if ({p0_wen, alu0_complete} !== 2'b00) begin
            failures++;
            $display("FAIL single_after: got %b expected 00", {p0_wen, alu0_complete});
        end
    endtask

    task automatic test_four();
        do_reset();
        for (int n = 0; n < 4; n++) set_src(n, 32'h1000 + 32'(n), 6'(n + 1), 5'(n + 10), 1'b1);
        tick();
        clear_inputs();
        checks++;
        if (req_rdy !== 4'b0011) begin
            failures++;
            $display("FAIL four_rdy_A: got %b expected 0011", req_rdy);
        end
        tick();
        checks++;
        if ({alu0_complete, alu1_complete, p0_we_data, p1_we_data, p1_we_dest, alu1_rob_id}
            !== {1'b1, 1'b1, 32'h1000, 32'h1001, 6'd2, 5'd11}) begin
            failures++;
            $display("FAIL four_A: got c=%b%b d0=%h d1=%h dest1=%0d rob1=%0d expected 11 1000 1001 2 11",
                     alu0_complete, alu1_complete, p0_we_data, p1_we_data, p1_we_dest, alu1_rob_id);
        end
        checks++;
        if (dut.rr_ptr !== 2'd2) begin
            failures++;
            $display("FAIL four_ptr_A: got %0d expected 2", dut.rr_ptr);
        end
        tick();
        checks++;
        if ({alu0_complete, alu1_complete, p0_we_data, p1_we_data, p0_we_dest, alu0_rob_id}
            !== {1'b1, 1'b1, 32'h1002, 32'h1003, 6'd3, 5'd12}) begin
            failures++;
            $display("FAIL four_B: got c=%b%b d0=%h d1=%h dest0=%0d rob0=%0d expected 11 1002 1003 3 12",
                     alu0_complete, alu1_complete, p0_we_data, p1_we_data, p0_we_dest, alu0_rob_id);
        end
        checks++;
        if (dut.rr_ptr !== 2'd0) begin
            failures++;
            $display("FAIL four_ptr_B: got %0d expected 0", dut.rr_ptr);
        end
        tick();
        checks++;
        if ({alu0_complete, alu1_complete} !== 2'b00) begin
            failures++;
            $display("FAIL four_drained: got %b expected 00", {alu0_complete, alu1_complete});
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_src(2, 32'h2222, 6'd3, 5'd2, 1'b1);
        tick();
        clear_inputs();
        set_src(3, 32'h3333, 6'd33, 5'd3, 1'b1);
        set_src(0, 32'h0A0A, 6'd40, 5'd4, 1'b1);
        tick();
        clear_inputs();
        checks++;
        if ({dut.rr_ptr, alu0_complete, alu1_complete, p0_we_data} !== {2'd3, 1'b1, 1'b0, 32'h2222}) begin
            failures++;
            $display("FAIL wrap_setup: got ptr=%0d c=%b%b d0=%h expected 3 10 2222",
                     dut.rr_ptr, alu0_complete, alu1_complete, p0_we_data);
        end
        tick();
        checks++;
        if ({alu0_complete, alu1_complete, p0_we_data, p1_we_data} !== {1'b1, 1'b1, 32'h3333, 32'h0A0A}) begin
            failures++;
            $display("FAIL wrap_grant: got c=%b%b d0=%h d1=%h expected 11 3333 0a0a",
                     alu0_complete, alu1_complete, p0_we_data, p1_we_data);
        end
        checks++;
        if (dut.rr_ptr !== 2'd1) begin
            failures++;
            $display("FAIL wrap_ptr: got %0d expected 1", dut.rr_ptr);
        end
    endtask

    task automatic test_completion_only();
        do_reset();
        set_src(2, 32'h5555, 6'd9, 5'd19, 1'b0);
        tick();
        clear_inputs();
        tick();
        checks++;
        if ({alu0_complete, alu0_rob_id, p0_wen, alu0_reg_ready, alu1_complete}
            !== {1'b1, 5'd19, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL compl_only: got cmp=%b rob=%0d wen=%b rr=%b cmp1=%b expected 1 19 0 0 0",
                     alu0_complete, alu0_rob_id, p0_wen, alu0_reg_ready, alu1_complete);
        end
    endtask

    task automatic test_flush();
        do_reset();
        set_src(0, 32'h0F0F, 6'd1, 5'd1, 1'b1);
        tick();
        clear_inputs();
        tick();
        for (int n = 0; n < 3; n++) set_src(n, 32'h3000 + 32'(n), 6'(n + 20), 5'(n), 1'b1);
        tick();
        clear_inputs();
        flush = 1'b1;
        set_src(0, 32'h3FFF, 6'd30, 5'd30, 1'b1);
        #1;
        checks++;
        if (req_rdy !== 4'hF) begin
            failures++;
            $display("FAIL flush_rdy: got %b expected 1111", req_rdy);
        end
        tick();
        flush = 1'b0;
        clear_inputs();
        checks++;
        if ({p0_wen, p1_wen, alu0_complete, alu1_complete} !== 4'b0) begin
            failures++;
            $display("FAIL flush_strobes: got %b expected 0000", {p0_wen, p1_wen, alu0_complete, alu1_complete});
        end
        checks++;
        if ({dut.rr_ptr, dut.buf_v} !== {2'd1, 4'b0}) begin
            failures++;
            $display("FAIL flush_state: got ptr=%0d bufv=%b expected 1 0000", dut.rr_ptr, dut.buf_v);
        end
        tick();
        checks++;
        if ({p0_wen, p1_wen, alu0_complete, alu1_complete, dut.buf_v} !== 8'b0) begin
            failures++;
            $display("FAIL flush_dropped: got %b bufv=%b expected 0000 0000",
                     {p0_wen, p1_wen, alu0_complete, alu1_complete}, dut.buf_v);
        end
    endtask

    task automatic test_back_to_back();
        int comps;
        comps = 0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            clear_inputs();
            if (k < 10) begin
                set_src(0, 32'hA000_0000 | 32'(k), 6'd5, 5'(k), 1'b1);
                set_src(1, 32'hB000_0000 | 32'(k), 6'd6, 5'(k), 1'b1);
                checks++;
                if (req_rdy[1:0] !== 2'b11) begin
                    failures++;
                    $display("FAIL b2b_rdy k=%0d: got %b expected 11", k, req_rdy[1:0]);
                end
            end
            if (k >= 2) begin
                comps += int'(alu0_complete) + int'(alu1_complete);
                checks++;
                if ({alu0_complete, alu1_complete, p0_we_data, p1_we_data}
                    !== {1'b1, 1'b1, 32'hA000_0000 | 32'(k - 2), 32'hB000_0000 | 32'(k - 2)}) begin
                    failures++;
                    $display("FAIL b2b_out k=%0d: got c=%b%b d0=%h d1=%h expected 11 %h %h", k,
                             alu0_complete, alu1_complete, p0_we_data, p1_we_data,
                             32'hA000_0000 | 32'(k - 2), 32'hB000_0000 | 32'(k - 2));
                end
            end
            tick();
        end
        clear_inputs();
        checks++;
        if (comps != 20) begin
            failures++;
            $display("FAIL b2b_count: got %0d expected 20", comps);
        end
    endtask

    task automatic test_three_stream();
        int sent [3];
        int rcvd [3];
        int last_g [3];
        int src;
        int k;
        logic [2:0] acc;
        for (int n = 0; n < 3; n++) begin
            sent[n] = 0;
            rcvd[n] = 0;
            last_g[n] = 1;
        end
        do_reset();
        k = 0;
        while (k < 40 && !(rcvd[0] == 10 && rcvd[1] == 10 && rcvd[2] == 10)) begin
            if (alu0_complete) begin
                src = int'(p0_we_data[31:28]);
                checks++;
                if (src > 2 || 32'(p0_we_data[15:0]) != 32'(rcvd[src % 3])) begin
                    failures++;
                    $display("FAIL s3_p0 k=%0d: got data=%h expected source<3 seq=%0d", k, p0_we_data, rcvd[src % 3]);
                end
                rcvd[src % 3]++;
                last_g[src % 3] = k;
            end
            if (alu1_complete) begin
                src = int'(p1_we_data[31:28]);
                checks++;
                if (src > 2 || 32'(p1_we_data[15:0]) != 32'(rcvd[src % 3])) begin
                    failures++;
                    $display("FAIL s3_p1 k=%0d: got data=%h expected source<3 seq=%0d", k, p1_we_data, rcvd[src % 3]);
                end
                rcvd[src % 3]++;
                last_g[src % 3] = k;
            end
            for (int n = 0; n < 3; n++) begin
                if (k >= 2 && rcvd[n] < 10) begin
                    checks++;
                    if (k - last_g[n] > 2) begin
                        failures++;
                        $display("FAIL s3_starve k=%0d src=%0d: got gap %0d expected <=2", k, n, k - last_g[n]);
                    end
                end
            end
            clear_inputs();
            for (int n = 0; n < 3; n++) begin
                if (sent[n] < 10) set_src(n, {4'(n), 12'h0, 16'(sent[n])}, 6'(n + 1), 5'(sent[n]), 1'b1);
            end
            #1;
            acc = req_vld[2:0] & req_rdy[2:0];
            tick();
            for (int n = 0; n < 3; n++) sent[n] += int'(acc[n]);
            k++;
        end
        clear_inputs();
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (rcvd[n] != 10) begin
                failures++;
                $display("FAIL s3_total src=%0d: got %0d expected 10", n, rcvd[n]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int n = 0; n < 4; n++) set_src(n, 32'h7000 + 32'(n), 6'(n + 7), 5'(n + 7), 1'b1);
        tick();
        clear_inputs();
        tick();
        for (int n = 0; n < 4; n++) set_src(n, 32'h8000 + 32'(n), 6'(n + 8), 5'(n + 8), 1'b1);
        flush = 1'b1;
        cpu_reset = 1'b1;
        tick();
        cpu_reset = 1'b0;
        flush = 1'b0;
        clear_inputs();
        checks++;
        if ({p0_wen, p1_wen, alu0_complete, alu1_complete, p0_we_data, p1_we_data,
             p0_we_dest, p1_we_dest, alu0_rob_id, alu1_rob_id} !== '0) begin
            failures++;
            $display("FAIL rst_mid_out: got c=%b%b d0=%h d1=%h rob=%0d/%0d expected all 0",
                     alu0_complete, alu1_complete, p0_we_data, p1_we_data, alu0_rob_id, alu1_rob_id);
        end
        checks++;
        if ({dut.rr_ptr, dut.buf_v} !== 6'b0) begin
            failures++;
            $display("FAIL rst_mid_state: got ptr=%0d bufv=%b expected 0 0000", dut.rr_ptr, dut.buf_v);
        end
    endtask

    initial begin
        cpu_reset = 1'b1;
        flush = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_four();
        test_wrap();
        test_completion_only();
        test_flush();
        test_back_to_back();
        test_three_stream();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the two integer register-file write ports (p0/p1) among NREQ execution-unit result sources, e.g. alu0, alu1, ivalu0, ivalu1, branch unit, and a future multi-cycle muldiv.
- Each source gets a one-entry holding buffer with a ready backpressure signal.
- A round-robin selector grants up to two buffered results per cycle.
- Granted results are registered onto the write-port, ROB-complete and wakeup outputs.
- Sits between the EX stages and the register file, CIFF and RST bitvectors.

Parameters:
- NREQ, 4, number of result sources (2..8).
- IDX_W, $clog2(NREQ), width of the round-robin pointer.

Ports:
- cpu_clock_i  in  1  clock
- cpu_reset_i  in  1  synchronous active-high reset
- flush_i  in  1  pipeline flush; discards all buffered and in-flight results
- req_vld_i  in  NREQ  source n presents a result
- req_wb_i  in  NREQ  result needs a register write (else completion only)
- req_data_i  in  NREQ*32  result data, source n at [32n+31:32n]
- req_dest_i  in  NREQ*6  physical destination register
- req_rob_i  in  NREQ*5  ROB id
- req_rdy_o  out  NREQ  buffer n can accept this cycle
- p0_wen / p1_wen  out  1  register-file write enable
- p0_we_data / p1_we_data  out  32  write data
- p0_we_dest / p1_we_dest  out  6  write destination
- alu0_complete / alu1_complete  out  1  ROB completion strobe for port 0 / port 1
- alu0_rob_id / alu1_rob_id  out  5  completing ROB id
- alu0_reg_ready / alu1_reg_ready  out  1  RST wakeup strobe (equals the matching wen)
- alu0_reg_dest / alu1_reg_dest  out  6  wakeup register (equals the matching we_dest)

Behaviour:
- Reset (cpu_reset_i=1 at an edge):
  - all buffer valid bits = 0, rr_ptr = 0;
  - all wen/complete/reg_ready = 0;
  - data/dest/rob outputs = 0.
  - Reset takes priority over flush and over any input.
- Buffer n:
  - req_rdy_o[n] = !buf_v[n] | grant[n]. The signal is combinational from buffer state and the grant.
  - Input is captured at the edge when req_vld_i[n] & req_rdy_o[n].
  - A grant and a new capture in the same cycle replace the entry; there is no bubble.
  - req_vld_i with req_rdy_o=0 is a source protocol error. The input is ignored and the buffer is unchanged.
  - The source must hold its result until accepted.
- Arbitration (combinational on buf_v):
  - Scan indices rr_ptr, rr_ptr+1, … mod NREQ.
  - The first valid entry goes to port 0, the second valid entry goes to port 1.
  - If only one entry is valid, port 1 idles.
- rr_ptr update: next = (index of last granted entry + 1) mod NREQ; unchanged if nothing is granted. Wrap-around at NREQ-1 → 0 is required.
- Output stage (registered, updated every edge):
  - pX_complete = granted;
  - pX_wen = granted & buffered wb bit;
  - data, dest and rob come from the granted entry.
  - When a port is not granted, its strobes are 0. Data/dest/rob hold their last value (don't-care).
- Latency:
  - Result accepted at edge N, buffer empty, no contention → outputs valid in the cycle after edge N+1.
  - Minimum 2 cycles from req_vld_i to the outputs.
- Starvation bound: an entry is granted within ceil(NREQ/2) cycles of becoming buffered.
- Ordering: p0 and p1 never carry the same source in one cycle. Two entries with the same dest are not checked; uniqueness is upstream's responsibility.
- Flush (flush_i=1 at an edge):
  - all buf_v ← 0; inputs that cycle are dropped;
  - all output strobes ← 0 at that edge;
  - rr_ptr is unchanged.
  - req_rdy_o remains 1 during the flush cycle.
- Sources with wb=0 (e.g. a branch without rd) consume a port slot for completion only; wen=0 and reg_ready=0.

Decomposition:
- Shared package (e.g. the integer math-system package) holds:
  - typedef wb_req_t {logic [31:0] data; logic [5:0] dest; logic [4:0] rob; logic wb;};
  - constants XLEN=32, PREG_W=6, ROB_W=5.
- One sub-module: rr_pick2, a combinational two-winner round-robin selector.
  - Inputs: vector [NREQ], rr_ptr.
  - Outputs: g0_v, g0_idx, g1_v, g1_idx, next_ptr.
- Buffers and the output register stay in the top-level module.

Test Plan:
- Single source, no contention:
  - Stimulus: reset, then one cycle of src1 vld with data=0xDEADBEEF, dest=12, rob=7, wb=1.
  - Response: two cycles later p0_wen=1, p0_we_data=0xDEADBEEF, p0_we_dest=12, alu0_complete=1, alu0_rob_id=7, alu0_reg_dest=12; port 1 idle; req_rdy_o stays 1.
- Four sources at once, rr_ptr=0:
  - Stimulus: all four sources vld in the same cycle.
  - Response: cycle A gives p0←src0, p1←src1 and rr_ptr=2. Cycle B gives p0←src2, p1←src3 and rr_ptr=0. During A, req_rdy_o=0011.
- Wrap-around:
  - Stimulus: rr_ptr=3, only src3 and src0 buffered.
  - Response: p0←src3, p1←src0, rr_ptr=1.
- Completion-only result:
  - Stimulus: src2 with wb=0, rob=19.
  - Response: alu0_complete=1, alu0_rob_id=19, p0_wen=0, alu0_reg_ready=0.
- Flush with buffered results:
  - Stimulus: three buffers full, flush_i pulsed one cycle concurrent with a new src0 request.
  - Response: the next cycle has all strobes 0, buf_v=0 and the src0 request dropped; rr_ptr is unchanged.
- Back-to-back streaming under contention:
  - Stimulus: src0 and src1 vld every cycle for 10 cycles.
  - Response: both granted every cycle, req_rdy_o=1 every cycle, 20 completions with no loss or duplication.
  - Repeat with src0..src2 streaming: each source gets ≥1 grant per 2 cycles.
- Reset mid-operation:
  - Stimulus: cpu_reset_i asserted while buffers are full and flush_i=1.
  - Response: all outputs 0 and rr_ptr=0 on the next cycle.
